// File: rtl/dmem_sram_bridge_pkg.sv
// Shared types and constants for the memory-stage to SRAM-bus bridge.
// State encoding, bus size codes and the legal store strobe patterns.
package dmem_sram_bridge_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StDone,
    StDrain
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [3:0] STRB_NONE = 4'b0000;
  localparam logic [3:0] STRB_B0   = 4'b0001;
  localparam logic [3:0] STRB_B1   = 4'b0010;
  localparam logic [3:0] STRB_B2   = 4'b0100;
  localparam logic [3:0] STRB_B3   = 4'b1000;
  localparam logic [3:0] STRB_H0   = 4'b0011;
  localparam logic [3:0] STRB_H1   = 4'b1100;
  localparam logic [3:0] STRB_W    = 4'b1111;
  // Three-byte strobes come from unaligned swl/swr and go out as a word access.
  localparam logic [3:0] STRB_L3   = 4'b0111;
  localparam logic [3:0] STRB_U3   = 4'b1110;

endpackage

// File: rtl/dmem_size_decode.sv
// Combinational strobe decode: legality, bus size and low address bits.
// Loads (all-zero strobe) pass the requested load size straight through.
module dmem_size_decode
  import dmem_sram_bridge_pkg::*;
(
  input  logic [3:0] wen_i,
  input  logic [1:0] ld_sz_i,
  input  logic [1:0] addr_lo_i,
  output logic       legal_o,
  output logic [1:0] size_o,
  output logic [1:0] addr_lo_o
);

  always_comb begin
    legal_o   = 1'b1;
    size_o    = ld_sz_i;
    addr_lo_o = addr_lo_i;
    case (wen_i)
      STRB_NONE: ;
      STRB_B0, STRB_B1, STRB_B2, STRB_B3: size_o = SIZE_BYTE;
      STRB_H0, STRB_H1:                   size_o = SIZE_HALF;
      STRB_W:                             size_o = SIZE_WORD;
      STRB_L3, STRB_U3: begin
        size_o    = SIZE_WORD;
        addr_lo_o = 2'b00;
      end
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_sram_bridge.sv
// Issues one SRAM-bus access per memory-stage instruction and stalls until it completes.
// Cancelled accesses whose address phase was accepted are drained before the next issue.
module dmem_sram_bridge
  import dmem_sram_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc_valid,
  input  logic [3:0]        acc_wen,
  input  logic [1:0]        acc_ld_sz,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [DATA_W-1:0] acc_wdata,
  input  logic              ms_advance,
  input  logic              cancel,
  output logic              mem_stall,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  output logic [3:0]        data_wstrb,
  input  logic              addr_ok,
  input  logic              data_ok,
  input  logic [DATA_W-1:0] rdata
);

  state_e            state_q, state_d;
  logic              data_req_q, data_req_d;
  logic              data_wr_q, data_wr_d;
  logic [1:0]        data_size_q, data_size_d;
  logic [ADDR_W-1:0] data_addr_q, data_addr_d;
  logic [DATA_W-1:0] data_wdata_q, data_wdata_d;
  logic [3:0]        data_wstrb_q, data_wstrb_d;
  logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;

  logic       dec_legal;
  logic [1:0] dec_size;
  logic [1:0] dec_addr_lo;
  logic       issue;

  dmem_size_decode u_size_decode (
    .wen_i     (acc_wen),
    .ld_sz_i   (acc_ld_sz),
    .addr_lo_i (acc_addr[1:0]),
    .legal_o   (dec_legal),
    .size_o    (dec_size),
    .addr_lo_o (dec_addr_lo)
  );

  assign issue = acc_valid & ~cancel & dec_legal;

  always_comb begin
    state_d      = state_q;
    data_req_d   = data_req_q;
    data_wr_d    = data_wr_q;
    data_size_d  = data_size_q;
    data_addr_d  = data_addr_q;
    data_wdata_d = data_wdata_q;
    data_wstrb_d = data_wstrb_q;
    ld_rdata_d   = ld_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (issue) begin
          state_d      = StReq;
          data_req_d   = 1'b1;
          data_wr_d    = |acc_wen;
          data_size_d  = dec_size;
          data_addr_d  = {acc_addr[ADDR_W-1:2], dec_addr_lo};
          data_wdata_d = acc_wdata;
          data_wstrb_d = acc_wen;
        end
      end
      StReq: begin
        // Request fields stay frozen until the bus takes the address phase.
        if (addr_ok) begin
          data_req_d = 1'b0;
          state_d    = cancel ? StDrain : StWait;
        end else if (cancel) begin
          data_req_d = 1'b0;
          state_d    = StIdle;
        end
      end
      StWait: begin
        if (data_ok) begin
          if (cancel) begin
            state_d = StIdle;
          end else begin
            state_d = StDone;
            if (!data_wr_q) ld_rdata_d = rdata;
          end
        end else if (cancel) begin
          state_d = StDrain;
        end
      end
      StDone: begin
        if (ms_advance || cancel) state_d = StIdle;
      end
      StDrain: begin
        if (data_ok) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      data_req_q   <= 1'b0;
      data_wr_q    <= 1'b0;
      data_size_q  <= 2'b00;
      data_addr_q  <= '0;
      data_wdata_q <= '0;
      data_wstrb_q <= 4'b0000;
      ld_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      data_req_q   <= data_req_d;
      data_wr_q    <= data_wr_d;
      data_size_q  <= data_size_d;
      data_addr_q  <= data_addr_d;
      data_wdata_q <= data_wdata_d;
      data_wstrb_q <= data_wstrb_d;
      ld_rdata_q   <= ld_rdata_d;
    end
  end

  assign mem_stall = ((state_q == StIdle) & acc_valid & ~cancel)
                   | (state_q == StReq)
                   | ((state_q == StWait) & ~cancel)
                   | ((state_q == StDrain) & acc_valid & ~cancel);

  assign data_req   = data_req_q;
  assign data_wr    = data_wr_q;
  assign data_size  = data_size_q;
  assign data_addr  = data_addr_q;
  assign data_wdata = data_wdata_q;
  assign data_wstrb = data_wstrb_q;
  assign ld_rdata   = ld_rdata_q;

endmodule

// File: doc/dmem_sram_bridge.md
Name: dmem_sram_bridge

Overview:
- Sequential bridge between the memory-stage store/load formatter (byte-enable, aligned address, shifted store data) and the SRAM-like data bus (req/addr_ok/data_ok).
- Issues one access per memory-stage instruction and stalls the pipeline until the access completes.
- Holds the returned load word for the load-alignment/splice stage until the pipeline advances.
- Drains and discards responses for accesses cancelled by exception or flush.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byte-enable width is DATA_W/8)

Ports:
clk        in   1      clock
rst        in   1      synchronous active-high reset
acc_valid  in   1      memory-stage instruction valid and carrying a memory op
acc_wen    in   4      store byte-enables (0000 = load)
acc_ld_sz  in   2      load size: 0 = byte, 1 = half, 2 = word
acc_addr   in   ADDR_W access address
acc_wdata  in   DATA_W pre-shifted store data
ms_advance in   1      memory stage hands its instruction on this cycle
cancel     in   1      exception/flush kills the current access
mem_stall  out  1      pipeline must hold the memory stage
ld_rdata   out  DATA_W captured load word (stable in DONE)
data_req   out  1      bus request
data_wr    out  1      1 = write
data_size  out  2      0 = byte, 1 = half, 2 = word
data_addr  out  ADDR_W bus address
data_wdata out  DATA_W bus write data
data_wstrb out  4      bus byte strobes
addr_ok    in   1      bus accepted the request
data_ok    in   1      bus returned data / write acknowledge
rdata      in   DATA_W bus read data

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- States: IDLE, REQ, WAIT, DONE, DRAIN.
- Reset: state = IDLE; data_req = 0; all bus output registers = 0; ld_rdata = 0.
- IDLE
  - acc_valid & !cancel: latch the request registers, go to REQ; mem_stall = 1 this cycle.
  - cancel: no issue.
- Latched request values
  - data_wr = |acc_wen.
  - Stores: size derived from the strobe. 0001/0010/0100/1000 -> 0; 0011/1100 -> 1; 1111, 0111, 1110 -> 2.
  - Stores with a 3-byte strobe: data_addr = acc_addr with [1:0] forced to 00.
  - Loads: size = acc_ld_sz; data_wstrb = 0000.
  - Any other strobe pattern is illegal: no issue, remain in IDLE.
- REQ: data_req = 1, bus outputs held stable until addr_ok.
  - addr_ok: -> WAIT, or -> DRAIN if cancel in the same cycle.
  - cancel & !addr_ok: drop req, -> IDLE.
- WAIT: data_req = 0.
  - data_ok & !cancel: ld_rdata <= rdata (loads only), -> DONE.
  - cancel & data_ok: -> IDLE.
  - cancel & !data_ok: -> DRAIN.
- DONE: mem_stall = 0; ld_rdata holds.
  - ms_advance or cancel: -> IDLE.
  - The same instruction is never reissued while in DONE.
- DRAIN: data_req = 0; wait for data_ok, discard rdata, -> IDLE.
  - mem_stall = acc_valid & !cancel, so a new access waits.
- mem_stall = (IDLE & acc_valid & !cancel) | REQ | (WAIT & !cancel) | (DRAIN & acc_valid & !cancel).
- Latency
  - Minimum 3 cycles from acc_valid to stall release: IDLE, REQ+addr_ok, WAIT+data_ok, then DONE.
  - data_ok arriving in the same cycle as addr_ok is ignored: at most one outstanding access, and data_ok is only counted in WAIT/DRAIN.
- rst in any state returns to IDLE at the next edge and drops data_req. A bus response still in flight after reset is the bus side's responsibility.
- Undefined response: data_ok seen in IDLE/REQ/DONE is ignored.

Decomposition:
- Shared defines header: state encodings, size codes SIZE_BYTE/HALF/WORD, strobe constants.
- One combinational sub-module, dmem_size_decode: strobe -> {legal, size, aligned addr[1:0]}.
- FSM and request registers live in the top module.

Test Plan:
1. Word load to 0x1000_0004, addr_ok on the 2nd REQ cycle, data_ok 2 cycles later with rdata = 0xDEAD_BEEF -> data_size = 2, data_wr = 0; mem_stall high for 5 cycles; ld_rdata = 0xDEADBEEF in DONE; one req handshake only.
2. sb, strobe 0100, addr 0x...06 -> data_wr = 1, data_size = 0, data_wstrb = 0100, data_addr ends in 0x6; DONE then IDLE on ms_advance.
3. swl, strobe 0111, addr 0x...0B -> data_size = 2, data_addr ends in 0x8.
4. cancel in WAIT with no data_ok, then a new load presented -> DRAIN; new req issued only after data_ok is consumed; mem_stall high throughout; discarded rdata never reaches ld_rdata.
5. cancel with addr_ok in the same REQ cycle -> DRAIN.
6. cancel in REQ without addr_ok -> data_req low next cycle, IDLE.
7. rst asserted in WAIT -> next cycle: IDLE, data_req = 0, ld_rdata = 0, mem_stall = 0 (acc_valid = 0).
8. Back-to-back accesses: load, then store with ms_advance held high -> the second req starts exactly one cycle after DONE->IDLE.
